// File: rtl/image_window_dma.sv
// Image DMA: streams rows into a rotating three-row line buffer, emits 3x3 windows over
// valid/ready, and packs result pixels into row words. IMAGE_WINDOW_EDGE_REPLICATE_EN clamps borders.
module image_window_dma #(
  parameter int unsigned PIX_W   = 12,
  parameter int unsigned IMG_W   = 256,
  parameter int unsigned IMG_H   = 256,
  parameter int unsigned NUM_IMG = 2,
  localparam int unsigned ROW_W  = IMG_W * PIX_W,
  localparam int unsigned SEL_W  = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1,
  localparam int unsigned ROWA_W = $clog2(IMG_H),
  localparam int unsigned COL_W  = $clog2(IMG_W),
  localparam int unsigned RA_W   = SEL_W + ROWA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SEL_W-1:0]     img_sel,
  output logic                 rd_en,
  output logic [RA_W-1:0]      raddr,
  input  logic [ROW_W-1:0]     rdata,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [9*PIX_W-1:0]   win_data,
  output logic [ROWA_W-1:0]    win_row,
  output logic [COL_W-1:0]     win_col,
  output logic                 busy,
  output logic                 done,
  input  logic                 wr_pix_valid,
  input  logic [PIX_W-1:0]     wr_pix,
  input  logic [SEL_W-1:0]     wr_img_sel,
  output logic                 we,
  output logic [RA_W-1:0]      waddr,
  output logic [ROW_W-1:0]     wdata
);

  localparam int ImgWI = int'(IMG_W);
  localparam int ImgHI = int'(IMG_H);

  typedef enum logic [2:0] {StIdle, StPrime0, StPrime1, StLoad, StRun, StFetch, StDone} state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [ROWA_W-1:0]    r_q, r_d, rd_row;
  logic [COL_W-1:0]     c_q, c_d;
  logic [1:0]           top_q, top_d;
  logic [ROW_W-1:0]     line_q [3];
  logic [ROW_W-1:0]     line_d [3];
  logic                 rd_pend_q;
  logic                 win_valid_q, win_valid_d, load_win;
  logic [9*PIX_W-1:0]   win_data_q, win_next;

  function automatic logic [1:0] slot_inc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic logic [1:0] slot_dec(input logic [1:0] s);
    return (s == 2'd0) ? 2'd2 : s - 2'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    r_d         = r_q;
    c_d         = c_q;
    top_d       = top_q;
    line_d      = line_q;
    win_valid_d = win_valid_q;
    load_win    = 1'b0;
    rd_en       = 1'b0;
    rd_row      = '0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPrime0;
          sel_d   = img_sel;
          r_d     = '0;
          c_d     = '0;
          top_d   = 2'd0;
          for (int i = 0; i < 3; i++) line_d[i] = '0;
        end
      end
      StPrime0: begin
        rd_en   = 1'b1;
        state_d = StPrime1;
      end
      StPrime1: begin
        rd_en     = 1'b1;
        rd_row    = ROWA_W'(1);
        line_d[1] = rdata;
`ifdef IMAGE_WINDOW_EDGE_REPLICATE_EN
        line_d[0] = rdata;
`endif
        state_d   = StLoad;
      end
      StLoad: begin
        // Bottom row arrives this cycle; the window mux bypasses rdata for it.
        if (rd_pend_q) line_d[slot_dec(top_q)] = rdata;
        load_win    = 1'b1;
        win_valid_d = 1'b1;
        state_d     = StRun;
      end
      StRun: begin
        if (win_valid_q && win_ready) begin
          if (c_q == COL_W'(IMG_W - 1)) begin
            win_valid_d = 1'b0;
            state_d     = (r_q == ROWA_W'(IMG_H - 1)) ? StDone : StFetch;
          end else begin
            c_d      = c_q + COL_W'(1);
            load_win = 1'b1;
          end
        end
      end
      StFetch: begin
        // The retiring top slot becomes the new bottom slot.
        top_d   = slot_inc(top_q);
        r_d     = r_q + ROWA_W'(1);
        c_d     = '0;
        state_d = StLoad;
        if (int'(r_q) + 2 <= ImgHI - 1) begin
          rd_en  = 1'b1;
          rd_row = r_q + ROWA_W'(2);
        end else begin
`ifdef IMAGE_WINDOW_EDGE_REPLICATE_EN
          line_d[top_q] = line_q[slot_dec(top_q)];
`else
          line_d[top_q] = '0;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    logic [ROW_W-1:0] rows [3];
    int col;
    rows[0]  = line_q[top_q];
    rows[1]  = line_q[slot_inc(top_q)];
    rows[2]  = rd_pend_q ? rdata : line_q[slot_dec(top_q)];
    win_next = '0;
    col      = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        col = int'(c_d) - 1 + j;
`ifdef IMAGE_WINDOW_EDGE_REPLICATE_EN
        if (col < 0) col = 0;
        else if (col > ImgWI - 1) col = ImgWI - 1;
        win_next[(3*i+j)*PIX_W +: PIX_W] = rows[i][col*PIX_W +: PIX_W];
`else
        if (col >= 0 && col < ImgWI) begin
          win_next[(3*i+j)*PIX_W +: PIX_W] = rows[i][col*PIX_W +: PIX_W];
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      top_q       <= 2'd0;
      for (int i = 0; i < 3; i++) line_q[i] <= '0;
      rd_pend_q   <= 1'b0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      r_q         <= r_d;
      c_q         <= c_d;
      top_q       <= top_d;
      line_q      <= line_d;
      rd_pend_q   <= rd_en;
      win_valid_q <= win_valid_d;
      if (load_win) win_data_q <= win_next;
    end
  end

  assign raddr     = {sel_q, rd_row};
  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_row   = r_q;
  assign win_col   = c_q;
  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);

  // Write-side packer, independent of the read FSM.
  logic [ROW_W-1:0]  wr_buf_q, wr_buf_d;
  logic [COL_W-1:0]  wr_col_q;
  logic [ROWA_W-1:0] wr_row_q;
  logic              we_q;
  logic [RA_W-1:0]   waddr_q;
  logic [ROW_W-1:0]  wdata_q;

  always_comb begin
    wr_buf_d = wr_buf_q;
    wr_buf_d[int'(wr_col_q)*PIX_W +: PIX_W] = wr_pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_buf_q <= '0;
      wr_col_q <= '0;
      wr_row_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      we_q <= 1'b0;
      if (start && state_q == StIdle) begin
        wr_col_q <= '0;
        wr_row_q <= '0;
      end else if (wr_pix_valid) begin
        wr_buf_q <= wr_buf_d;
        if (wr_col_q == COL_W'(IMG_W - 1)) begin
          we_q     <= 1'b1;
          wdata_q  <= wr_buf_d;
          waddr_q  <= {wr_img_sel, wr_row_q};
          wr_col_q <= '0;
          wr_row_q <= (wr_row_q == ROWA_W'(IMG_H - 1)) ? '0 : wr_row_q + ROWA_W'(1);
        end else begin
          wr_col_q <= wr_col_q + COL_W'(1);
        end
      end
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_image_window_dma.sv
// Self-checking bench for image_window_dma: 8x4 images, pixel(r,c) = 256*img + 16r + c.
`timescale 1ns/1ps
module tb_image_window_dma;

  localparam int PIX_W = 12;
  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int ROW_W = IMG_W * PIX_W;
  localparam int WIN_W = 9 * PIX_W;
  localparam int NPIX  = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [0:0]       img_sel = 1'b0;
  logic             rd_en;
  logic [2:0]       raddr;
  logic [ROW_W-1:0] rdata = '0;
  logic             win_valid;
  logic             win_ready = 1'b1;
  logic [WIN_W-1:0] win_data;
  logic [1:0]       win_row;
  logic [2:0]       win_col;
  logic             busy, done;
  logic             wr_pix_valid = 1'b0;
  logic [PIX_W-1:0] wr_pix = '0;
  logic [0:0]       wr_img_sel = 1'b0;
  logic             we;
  logic [2:0]       waddr;
  logic [ROW_W-1:0] wdata;

  image_window_dma #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_IMG(2)) dut (
    .clk(clk), .rst(rst), .start(start), .img_sel(img_sel), .rd_en(rd_en), .raddr(raddr),
    .rdata(rdata), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .busy(busy), .done(done),
    .wr_pix_valid(wr_pix_valid), .wr_pix(wr_pix), .wr_img_sel(wr_img_sel), .we(we),
    .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int pix(input int img, input int r, input int c);
    return 256 * img + 16 * r + c;
  endfunction

  function automatic logic [ROW_W-1:0] row_word(input int img, input int r);
    logic [ROW_W-1:0] w;
    w = '0;
    for (int k = 0; k < IMG_W; k++) w[k*PIX_W +: PIX_W] = PIX_W'(pix(img, r, k));
    return w;
  endfunction

  function automatic logic [WIN_W-1:0] model_win(input int img, input int r, input int c);
    logic [WIN_W-1:0] w;
    int rr, cc;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        rr = r - 1 + i;
        cc = c - 1 + j;
`ifdef IMAGE_WINDOW_EDGE_REPLICATE_EN
        rr = (rr < 0) ? 0 : (rr > IMG_H - 1) ? IMG_H - 1 : rr;
        cc = (cc < 0) ? 0 : (cc > IMG_W - 1) ? IMG_W - 1 : cc;
        w[(3*i+j)*PIX_W +: PIX_W] = PIX_W'(pix(img, rr, cc));
`else
        if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W)
          w[(3*i+j)*PIX_W +: PIX_W] = PIX_W'(pix(img, rr, cc));
`endif
      end
    end
    return w;
  endfunction

  function automatic logic [WIN_W-1:0] pack9(input int p0, input int p1, input int p2,
                                              input int p3, input int p4, input int p5,
                                              input int p6, input int p7, input int p8);
    return {PIX_W'(p8), PIX_W'(p7), PIX_W'(p6), PIX_W'(p5), PIX_W'(p4),
            PIX_W'(p3), PIX_W'(p2), PIX_W'(p1), PIX_W'(p0)};
  endfunction

  function automatic logic [255:0] all_outs();
    return 256'({rd_en, raddr, win_valid, win_data, win_row, win_col, busy, done,
                 we, waddr, wdata});
  endfunction

  // Image buffer: registered read, data the cycle after rd_en.
  always @(posedge clk) if (rd_en) rdata <= row_word(int'(raddr[2]), int'(raddr[1:0]));

  typedef struct {
    logic [2:0]       a;
    logic [ROW_W-1:0] d;
    int               c;
  } we_exp_t;
  we_exp_t weq[$];

  int               cur_img = 0;
  int               exp_idx = 0;
  int               done_cnt = 0;
  int               done_cyc = 0;
  int               first_valid_cyc = -1;
  int               we_cnt = 0;
  bit               stall_prev = 1'b0;
  logic [112:0]     prev_out = '0;
  logic [WIN_W-1:0] got [NPIX];
  logic [2:0]       first_waddr = '0, last_waddr = '0;
  logic [ROW_W-1:0] first_wdata = '0;

  always @(negedge clk) begin
    if (win_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stall_prev) check("win_stable", 256'({win_row, win_col, win_data}), 256'(prev_out));
      if (win_ready) begin
        check("win_in_frame", 256'(exp_idx < NPIX), 256'(1));
        if (exp_idx < NPIX) begin
          check("win_data", 256'(win_data),
                256'(model_win(cur_img, exp_idx / IMG_W, exp_idx % IMG_W)));
          check("win_pos", 256'({win_row, win_col}),
                256'({2'(exp_idx / IMG_W), 3'(exp_idx % IMG_W)}));
          got[exp_idx] = win_data;
        end
        exp_idx++;
      end
    end else if (stall_prev) begin
      check("win_valid_hold", 256'(win_valid), 256'(1));
    end
    stall_prev = win_valid && !win_ready;
    prev_out   = {win_row, win_col, win_data};
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rd_en) check("raddr_sel", 256'(raddr[2]), 256'(cur_img));
    if (we) begin
      we_cnt++;
      check("we_expected", 256'(weq.size() > 0), 256'(1));
      if (weq.size() > 0) begin
        we_exp_t e;
        e = weq.pop_front();
        check("we_cycle", 256'(cyc), 256'(e.c));
        check("waddr", 256'(waddr), 256'(e.a));
        check("wdata", 256'(wdata), 256'(e.d));
      end
      if (we_cnt == 1) begin
        first_waddr = waddr;
        first_wdata = wdata;
      end
      last_waddr = waddr;
    end
  end

  task automatic run_frame(input int img, input bit rand_ready, input bit dbl_start);
    int start_cyc;
    int k;
    cur_img = img;
    exp_idx = 0;
    done_cnt = 0;
    first_valid_cyc = -1;
    @(posedge clk); #1;
    img_sel   = 1'(img);
    start     = 1'b1;
    win_ready = 1'b1;
    start_cyc = cyc;
    k = 0;
    do begin
      @(posedge clk); #1;
      start     = dbl_start && (k == 9);
      img_sel   = (img == 0) ? 1'b1 : 1'b0;
      win_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      k++;
    end while (done_cnt == 0 && k < 400);
    @(posedge clk); #1;
    start     = 1'b0;
    win_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("frame_windows", 256'(exp_idx), 256'(NPIX));
    check("frame_done_count", 256'(done_cnt), 256'(1));
    check("first_valid_cycle", 256'(first_valid_cyc - start_cyc), 256'(4));
    if (!rand_ready) check("done_cycle", 256'(done_cyc - start_cyc), 256'(4 + NPIX + 3 * 2));
    check("busy_after_frame", 256'(busy), 256'(0));
  endtask

  task automatic write_rows(input int nrows);
    for (int row = 0; row < nrows; row++) begin
      logic [ROW_W-1:0] w;
      w = '0;
      for (int k = 0; k < IMG_W; k++) begin
        @(posedge clk); #1;
        wr_pix_valid = 1'b1;
        wr_img_sel   = 1'b1;
        wr_pix       = PIX_W'(32'h100 + 16 * row + k);
        w[k*PIX_W +: PIX_W] = wr_pix;
        if (k == IMG_W - 1) weq.push_back('{a: {1'b1, 2'(row % IMG_H)}, d: w, c: cyc + 1});
      end
    end
    @(posedge clk); #1;
    wr_pix_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Full frame, consumer always ready.
    run_frame(0, 1'b0, 1'b0);
`ifdef IMAGE_WINDOW_EDGE_REPLICATE_EN
    check("lit_win_0_0", 256'(got[0]), 256'(pack9(0, 0, 1, 0, 0, 1, 16, 16, 17)));
    check("lit_win_3_7", 256'(got[31]), 256'(pack9(38, 39, 39, 54, 55, 55, 54, 55, 55)));
`else
    check("lit_win_0_0", 256'(got[0]), 256'(pack9(0, 0, 0, 0, 0, 1, 0, 16, 17)));
    check("lit_win_3_7", 256'(got[31]), 256'(pack9(38, 39, 0, 54, 55, 0, 0, 0, 0)));
`endif
    check("lit_win_2_5", 256'(got[21]), 256'(pack9(20, 21, 22, 36, 37, 38, 52, 53, 54)));

    // Random backpressure.
    run_frame(0, 1'b1, 1'b0);

    // Image 1 with a start pulse while busy.
    run_frame(1, 1'b0, 1'b1);

    // Reset mid-RUN with a partial write row pending.
    cur_img  = 0;
    exp_idx  = 0;
    done_cnt = 0;
    we_cnt   = 0;
    @(posedge clk); #1;
    img_sel = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_pix_valid = 1'b1;
      wr_pix       = PIX_W'(k + 5);
      @(posedge clk); #1;
    end
    wr_pix_valid = 1'b0;
    for (int k = 0; k < 100 && exp_idx < 5; k++) @(negedge clk);
    check("reset_reached_run", 256'(exp_idx >= 5), 256'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrun_reset_outputs", all_outs(), 256'(0));
    repeat (60) @(negedge clk);
    check("midrun_no_done", 256'(done_cnt), 256'(0));
    check("midrun_no_we", 256'(we_cnt), 256'(0));
    check("midrun_idle", 256'({busy, win_valid}), 256'(0));

    // Write packing: five rows, the fifth wraps to row 0.
    we_cnt = 0;
    write_rows(5);
    repeat (4) @(negedge clk);
    check("we_count", 256'(we_cnt), 256'(5));
    check("we_queue_drained", 256'(weq.size()), 256'(0));
    check("lit_first_waddr", 256'(first_waddr), 256'(3'b100));
    check("lit_first_p0", 256'(first_wdata[11:0]), 256'(12'h100));
    check("lit_first_p7", 256'(first_wdata[95:84]), 256'(12'h107));
    check("lit_wrap_waddr", 256'(last_waddr), 256'(3'b100));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
